// File: rtl/store_merge_unit_if.sv
// Bus bundle for store_merge_unit: the store request/response handshake
// toward the requester and the word-wide read/write port toward memory.
interface store_merge_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [1:0]        ssel;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  // DUT side
  modport slave (
    input  start, addr, wdata, ssel, mem_rdata, mem_ready,
    output busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );

  // Requester / memory model side
  modport master (
    output start, addr, wdata, ssel, mem_rdata, mem_ready,
    input  busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit: turns a byte/half/word store into whole-word memory
// traffic. Sub-word stores do read-modify-write; word stores write directly;
// misaligned or reserved-size requests complete at once with err set.
module store_merge_unit #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  store_merge_unit_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_ssel;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mdata;
  logic              r_err;
  logic              w_illegal;
  logic              w_accept;

  // Insert the store data into the read word at the lane picked by the
  // low address bits; upper wdata bits beyond the store size are dropped.
  function automatic logic [31:0] f_merge(input logic [31:0] rd,
                                          input logic [31:0] wd,
                                          input logic [1:0]  sel,
                                          input logic [1:0]  off);
    logic [31:0] m;
    m = rd;
    case (sel)
      2'b00: begin
        case (off)
          2'd0:    m[7:0]   = wd[7:0];
          2'd1:    m[15:8]  = wd[7:0];
          2'd2:    m[23:16] = wd[7:0];
          2'd3:    m[31:24] = wd[7:0];
          default: m        = rd;
        endcase
      end
      2'b01: begin
        if (off[1]) m[31:16] = wd[15:0];
        else        m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.start;

  // Classify the incoming request: reserved size or misaligned half/word
  always_comb begin
    w_illegal = 1'b0;
    case (bus.ssel)
      2'b00:   w_illegal = 1'b0;
      2'b01:   w_illegal = bus.addr[0];
      2'b10:   w_illegal = (bus.addr[1:0] != 2'b00);
      default: w_illegal = 1'b1;
    endcase
  end

  // Next-state logic; word stores skip the read, rejects go straight to DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_illegal)              w_next = S_DONE;
          else if (bus.ssel == 2'b10) w_next = S_WRITE;
          else                        w_next = S_READ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_READ: begin
        if (bus.mem_ready) w_next = S_MERGE;
        else               w_next = S_READ;
      end
      S_MERGE: w_next = S_WRITE;
      S_WRITE: begin
        if (bus.mem_ready) w_next = S_DONE;
        else               w_next = S_WRITE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request capture, read-data capture and merged-word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
      r_ssel  <= 2'b00;
      r_rdata <= 32'h0000_0000;
      r_mdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_ssel  <= bus.ssel;
        r_err   <= w_illegal;
        // Word stores bypass MERGE, so the write word is loaded here
        if (!w_illegal && (bus.ssel == 2'b10)) r_mdata <= bus.wdata;
      end
      if ((r_state == S_READ) && bus.mem_ready) r_rdata <= bus.mem_rdata;
      if (r_state == S_MERGE) r_mdata <= f_merge(r_rdata, r_wdata, r_ssel, r_addr[1:0]);
    end
  end

  // Outputs are decoded from state or driven straight from registers
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = (r_state == S_DONE) && r_err;
  assign bus.mem_re    = (r_state == S_READ);
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata = r_mdata;

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of the byte address and memory address buses.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1, meaning a store request, sampled only when busy=0.
REQ-005 The block SHALL have port addr, input, ADDR_W, meaning the byte address of the store.
REQ-006 The block SHALL have port wdata, input, 32, meaning the store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 The block SHALL have port ssel, input, 2, meaning the store size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 The block SHALL have port busy, output, 1, meaning a request is in progress (state not IDLE).
REQ-009 The block SHALL have port done, output, 1, meaning a one-cycle completion pulse.
REQ-010 The block SHALL have port err, output, 1, meaning the completing request was rejected; valid only while done=1.
REQ-011 The block SHALL have port mem_addr, output, ADDR_W, meaning the word address {addr[ADDR_W-1:2],2'b00}.
REQ-012 The block SHALL have port mem_re, output, 1, meaning a memory read request.
REQ-013 The block SHALL have port mem_rdata, input, 32, meaning the read word, valid on the edge where mem_re=1 and mem_ready=1.
REQ-014 The block SHALL have port mem_we, output, 1, meaning a memory write request.
REQ-015 The block SHALL have port mem_wdata, output, 32, meaning the merged word to write.
REQ-016 The block SHALL have port mem_ready, input, 1, meaning the memory accepts the current mem_re/mem_we on this edge.

Function
REQ-017 The block SHALL implement the states IDLE, READ, MERGE, WRITE and DONE, with all outputs registered or decoded from state.
REQ-018 In IDLE, start=1 SHALL latch addr, wdata and ssel into internal registers; start SHALL be ignored in every other state.
REQ-019 A request SHALL be rejected when ssel=11, when ssel=01 and addr[0]=1, or when ssel=10 and addr[1:0]!=00; a rejected request SHALL go IDLE->DONE with err=1 and assert neither mem_re nor mem_we.
REQ-020 A legal byte or half request SHALL transition IDLE->READ; a legal word request SHALL transition IDLE->WRITE, skipping the read.
REQ-021 In READ, mem_re SHALL be held at 1 until an edge with mem_ready=1, which captures mem_rdata and moves the state to MERGE.
REQ-022 MERGE SHALL last exactly one cycle, compute the merged word into a register and move the state to WRITE.
REQ-023 A byte merge SHALL replace bits [8k+7:8k] of the read word with wdata[7:0], where k=addr[1:0], and keep all other bits.
REQ-024 A half merge SHALL replace bits [16h+15:16h] of the read word with wdata[15:0], where h=addr[1], and keep all other bits.
REQ-025 A word store SHALL drive mem_wdata = wdata.
REQ-026 In WRITE, mem_we SHALL be held at 1 with mem_wdata stable until an edge with mem_ready=1, which moves the state to DONE.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE; err SHALL be 0 for legal requests.
REQ-028 With mem_ready tied to 1, done SHALL rise 4 cycles after the start edge for byte/half, 2 cycles for word, and 1 cycle for rejected requests.
REQ-029 Each mem_ready wait cycle SHALL add exactly one cycle of latency.
REQ-030 mem_re and mem_we SHALL never be asserted in the same cycle.
REQ-031 mem_addr SHALL hold stable from the start edge until the state leaves WRITE.
REQ-032 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-033 When rst_n=0 the block SHALL asynchronously force IDLE with busy=0, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, and clear the internal registers.
REQ-034 Asserting reset mid-request SHALL immediately deassert mem_re/mem_we, abort the request without a done pulse, and accept a new start on the first edge after release.

Verification
REQ-035 Byte store: mem_rdata=0xAABBCCDD, addr=0x...2, wdata=0x11, ssel=00, ready=1 -> one read, then mem_wdata=0xAA11CCDD, done at cycle 4, err=0.
REQ-036 Half store: rdata=0xAABBCCDD, addr=0x...2, wdata=0x1234, ssel=01 -> mem_wdata=0x1234CCDD; with addr=0x...0 -> mem_wdata=0xAABB1234.
REQ-037 Word store: addr=0x100, wdata=0xDEADBEEF, ssel=10 -> no mem_re, mem_we with 0xDEADBEEF, done at cycle 2.
REQ-038 Rejects: half at addr=0x...1, word at 0x...2, ssel=11 -> done+err after 1 cycle, no memory access.
REQ-039 Backpressure: mem_ready=0 for 3 cycles in READ and 2 in WRITE -> done at cycle 9, signals stable, start during busy ignored.
REQ-040 Reset mid-operation: rst_n low during WRITE -> mem_we=0 immediately, no done pulse, next byte store completes correctly.
